// File: rtl/psion_lcd_pkg.sv
// Shared types and elaboration helpers for the Psion LCD scan controller.
package psion_lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    LOAD,
    GAP
  } state_t;

  function automatic int words_of(input int h_pixels, input int bus_w);
    return h_pixels / bus_w;
  endfunction

  function automatic bit params_ok(input int h_pixels, input int bus_w, input int clk_div);
    return (h_pixels % bus_w == 0) && (clk_div % 2 == 0) && (clk_div >= 4);
  endfunction

endpackage

// File: rtl/psion_lcd_timing.sv
// LCD period phase counter with per-period strobes; holds at phase 0 while run is low.
module psion_lcd_timing
  import psion_lcd_pkg::*;
#(
  parameter int CLK_DIV = 8,
  localparam int PH_W = $clog2(CLK_DIV)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PH_W-1:0] phase,
  output logic            period_start,
  output logic            data_latch,
  output logic            clk_rise
);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      phase <= '0;
    end else if (phase == PH_W'(CLK_DIV - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // period_start and clk_rise fire one clk early so registered outputs change
  // exactly on the phase they name; data_latch fires while read data is valid.
  assign period_start = run && (phase == PH_W'(CLK_DIV - 1));
  assign clk_rise     = run && (phase == PH_W'(CLK_DIV / 2 - 1));
  assign data_latch   = run && (phase == PH_W'(1));

endmodule

// File: rtl/psion_lcd_scan.sv
// Frame/line scan FSM streaming framebuffer words (or a checkerboard) onto a
// frame/line-load/pixel-clock/nibble-data passive LCD bus.
module psion_lcd_scan
  import psion_lcd_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 240,
  parameter int BUS_W    = 4,
  parameter int CLK_DIV  = 8,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pattern_sel,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [BUS_W-1:0]  fb_data,
  output logic              lcd_clk,
  output logic              lcd_line,
  output logic              lcd_frame,
  output logic [BUS_W-1:0]  lcd_data,
  output logic              lcd_en_n,
  output logic              busy,
  output logic              frame_done
);

  localparam int WORDS = words_of(H_PIXELS, BUS_W);
  localparam int TOTAL = WORDS * V_LINES;
  localparam int X_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int Y_W   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int PH_W  = $clog2(CLK_DIV);

  generate
    if (!params_ok(H_PIXELS, BUS_W, CLK_DIV) || ((64'd1 << ADDR_W) < 64'(TOTAL))) begin : g_bad_params
      $error("psion_lcd_scan: illegal geometry or clock division");
    end
  endgenerate

  state_t          state;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic            pattern;
  logic [PH_W-1:0] phase;
  logic            period_start;
  logic            data_latch;
  logic            clk_rise;
  logic            last_word;
  logic            last_line;
  logic            last_addr;

  assign last_word = (x == X_W'(WORDS - 1));
  assign last_line = (y == Y_W'(V_LINES - 1));
  assign last_addr = (fb_addr == ADDR_W'(TOTAL - 1));

  psion_lcd_timing #(
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .run         (state != IDLE),
    .phase       (phase),
    .period_start(period_start),
    .data_latch  (data_latch),
    .clk_rise    (clk_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      pattern    <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      lcd_clk    <= 1'b0;
      lcd_line   <= 1'b0;
      lcd_frame  <= 1'b0;
      lcd_data   <= '0;
      lcd_en_n   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fb_rd_en   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            pattern  <= pattern_sel;
            fb_rd_en <= !pattern_sel;
            lcd_en_n <= 1'b0;
            busy     <= 1'b1;
            x        <= '0;
            y        <= '0;
            fb_addr  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (data_latch) begin
            lcd_data <= pattern ? {BUS_W{x[0] ^ y[0]}} : fb_data;
          end
          if (clk_rise) begin
            lcd_clk <= 1'b1;
          end
          if (period_start) begin
            lcd_clk <= 1'b0;
            fb_addr <= last_addr ? '0 : fb_addr + 1'b1;
            if (last_word) begin
              state     <= LOAD;
              lcd_line  <= 1'b1;
              lcd_frame <= last_line;
            end else begin
              x        <= x + 1'b1;
              fb_rd_en <= !pattern;
            end
          end
        end
        LOAD: begin
          if (period_start) begin
            lcd_line <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          // Registered one clk ahead so the pulse lands on the frame's last clk.
          if (last_line && phase == PH_W'(CLK_DIV - 2)) begin
            frame_done <= 1'b1;
          end
          if (period_start) begin
            lcd_frame <= 1'b0;
            x         <= '0;
            if (!last_line) begin
              y        <= y + 1'b1;
              fb_rd_en <= !pattern;
              state    <= DATA;
            end else begin
              y       <= '0;
              fb_addr <= '0;
              if (enable) begin
                pattern  <= pattern_sel;
                fb_rd_en <= !pattern_sel;
                state    <= DATA;
              end else begin
                lcd_en_n <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
